// File: rtl/sc_io_input_port_if.sv
// Read-side bus of the data-memory IO window.
// The CPU drives addr/re; the port returns dataout and irq.
interface sc_io_input_port_if;
    logic [31:0] addr;
    logic        re;
    logic [31:0] dataout;
    logic        irq;

    modport master (
        output addr,
        output re,
        input  dataout,
        input  irq
    );

    modport slave (
        input  addr,
        input  re,
        output dataout,
        output irq
    );
endinterface

// File: rtl/sc_io_input_port.sv
// Memory-mapped input port: synchronised, debounced switches and keys
// with a sticky read-to-clear event register and a level irq.
module sc_io_input_port #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           switch_input,
    input  logic [3:0]           key_input,
    sc_io_input_port_if.slave    bus
);

    localparam int NB = 12;
    // Keys are active-low, so their idle level is 1.
    localparam logic [NB-1:0] RST_LVL = 12'hF00;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] A_SW_LO  = 32'hffffff60;
    localparam logic [31:0] A_SW_HI  = 32'hffffff64;
    localparam logic [31:0] A_SW_ALL = 32'hffffff68;
    localparam logic [31:0] A_STATUS = 32'hffffff6c;
    localparam logic [31:0] A_KEYS   = 32'hffffff70;

    logic [NB-1:0]    sync1_q, sync1_d;
    logic [NB-1:0]    sync2_q, sync2_d;
    logic [NB-1:0]    stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [NB-1:0]    status_q, status_d;
    logic [31:0]      dataout_q, dataout_d;
    logic             irq_q, irq_d;

    logic [NB-1:0]    events;
    logic [NB-1:0]    clr;

    always_comb begin
        sync1_d  = {key_input, switch_input};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        // Switch events on either edge, key events on press only.
        events = {stable_q[11:8] & ~stable_d[11:8],
                  stable_q[7:0] ^ stable_d[7:0]};

        clr       = '0;
        dataout_d = dataout_q;
        if (bus.re) begin
            unique case (bus.addr)
                A_SW_LO:  dataout_d = {28'b0, stable_q[3:0]};
                A_SW_HI:  dataout_d = {28'b0, stable_q[7:4]};
                A_SW_ALL: dataout_d = {24'b0, stable_q[7:0]};
                A_STATUS: begin
                    dataout_d = {20'b0, status_q};
                    clr       = status_q;
                end
                A_KEYS:   dataout_d = {28'b0, ~stable_q[11:8]};
                default:  dataout_d = '0;
            endcase
        end

        // A new event beats a coinciding clear.
        status_d = (status_q & ~clr) | events;
        irq_d    = |status_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= RST_LVL;
            sync2_q   <= RST_LVL;
            stable_q  <= RST_LVL;
            cnt_q     <= '{default: '0};
            status_q  <= '0;
            dataout_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            status_q  <= status_d;
            dataout_q <= dataout_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.dataout = dataout_q;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_sc_io_input_port.sv
// Bench for sc_io_input_port: directed vectors plus random traffic
// checked every cycle against a sliding-window reference model.
module tb_sc_io_input_port;

    localparam int D = 4;

    logic       clock  = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] sw_in  = 8'h00;
    logic [3:0] key_in = 4'hF;

    sc_io_input_port_if bus();

    sc_io_input_port #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clock(clock),
        .reset(rst),
        .switch_input(sw_in),
        .key_input(key_in),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [11:0] hist[$];
    logic [11:0] m_stable = 12'hF00;
    logic [11:0] m_status = '0;
    logic [31:0] m_dout   = '0;
    logic        m_irq    = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] addrs[7];

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(12'hF00);
        m_stable = 12'hF00;
        m_status = '0;
        m_dout   = '0;
        m_irq    = 1'b0;
    endtask

    // A bit of stable flips once the last D synchronised samples
    // (raw values from 2..D+1 edges ago) all disagree with it.
    task automatic m_edge();
        logic [11:0] ns;
        logic [11:0] ev;
        logic [11:0] clr;
        logic        all_diff;
        int          n;
        if (rst) begin
            m_reset();
        end else begin
            n  = hist.size();
            ns = m_stable;
            for (int b = 0; b < 12; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++)
                    if (hist[n-2-k][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) ns[b] = ~m_stable[b];
            end
            ev[7:0]  = ns[7:0] ^ m_stable[7:0];
            ev[11:8] = m_stable[11:8] & ~ns[11:8];
            clr = '0;
            if (bus.re) begin
                case (bus.addr)
                    32'hffffff60: m_dout = {28'b0, m_stable[3:0]};
                    32'hffffff64: m_dout = {28'b0, m_stable[7:4]};
                    32'hffffff68: m_dout = {24'b0, m_stable[7:0]};
                    32'hffffff6c: begin
                        m_dout = {20'b0, m_status};
                        clr    = m_status;
                    end
                    32'hffffff70: m_dout = {28'b0, ~m_stable[11:8]};
                    default:      m_dout = '0;
                endcase
            end
            m_status = (m_status & ~clr) | ev;
            m_irq    = |m_status;
            m_stable = ns;
            hist.push_back({key_in, sw_in});
            void'(hist.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clock);
        m_edge();
        #1;
        chk("model_dout", bus.dataout, m_dout);
        chk("model_irq", {31'b0, bus.irq}, {31'b0, m_irq});
    endtask

    task automatic rd(logic [31:0] a);
        bus.addr = a;
        bus.re   = 1'b1;
        step();
        bus.re   = 1'b0;
        bus.addr = '0;
    endtask

    task automatic chk_irq(string name, logic exp);
        chk(name, {31'b0, bus.irq}, {31'b0, exp});
    endtask

    initial begin
        vecs[0] = '{32'hffffff60, 32'h5, 1'b1};
        vecs[1] = '{32'hffffff64, 32'hA, 1'b1};
        vecs[2] = '{32'hffffff68, 32'hA5, 1'b1};
        vecs[3] = '{32'hffffff70, 32'h0, 1'b1};
        vecs[4] = '{32'hffffff74, 32'h0, 1'b1};
        vecs[5] = '{32'h00000060, 32'h0, 1'b1};
        vecs[6] = '{32'hffffff6c, 32'hA5, 1'b0};
        vecs[7] = '{32'hffffff6c, 32'h0, 1'b0};

        addrs = '{32'hffffff60, 32'hffffff64, 32'hffffff68,
                  32'hffffff6c, 32'hffffff70, 32'hffffff74,
                  32'h00000060};

        m_reset();
        bus.addr = '0;
        bus.re   = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // 1: reset values
        rd(32'hffffff68);
        chk("rst_sw", bus.dataout, 32'h0);
        chk_irq("rst_irq", 1'b0);
        rd(32'hffffff70);
        chk("rst_key", bus.dataout, 32'h0);

        // 2: switch latency and register map
        sw_in = 8'hA5;
        repeat (5) step();
        chk_irq("sw_early", 1'b0);
        step();
        chk_irq("sw_on_time", 1'b1);
        for (int i = 0; i < 8; i++) begin
            rd(vecs[i].addr);
            chk($sformatf("vec%0d_dout", i), bus.dataout,
                vecs[i].exp_dout);
            chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end

        // 3: key glitch, press, release
        key_in = 4'b1011;
        repeat (3) step();
        key_in = 4'hF;
        repeat (10) step();
        chk_irq("glitch_irq", 1'b0);
        rd(32'hffffff70);
        chk("glitch_key", bus.dataout, 32'h0);
        key_in = 4'b1011;
        repeat (10) step();
        rd(32'hffffff70);
        chk("press_key", bus.dataout, 32'h4);
        chk_irq("press_irq", 1'b1);
        rd(32'hffffff6c);
        chk("press_status", bus.dataout, 32'h400);
        chk_irq("press_clr_irq", 1'b0);
        key_in = 4'hF;
        repeat (10) step();
        chk_irq("release_irq", 1'b0);
        rd(32'hffffff6c);
        chk("release_status", bus.dataout, 32'h0);

        // 4: clearing read coincides with an event
        sw_in = 8'hA4;
        repeat (5) step();
        bus.addr = 32'hffffff6c;
        bus.re   = 1'b1;
        step();
        bus.re   = 1'b0;
        chk("coin_dout", bus.dataout, 32'h0);
        chk_irq("coin_irq", 1'b1);
        step();
        chk_irq("coin_irq_hold", 1'b1);
        rd(32'hffffff6c);
        chk("coin_next", bus.dataout, 32'h1);
        chk_irq("coin_clr_irq", 1'b0);

        // 5: unmapped reads and hold
        sw_in = 8'hA5;
        repeat (8) step();
        chk_irq("t5_irq", 1'b1);
        rd(32'hffffff68);
        chk("t5_sw", bus.dataout, 32'hA5);
        repeat (4) step();
        chk("t5_hold", bus.dataout, 32'hA5);
        rd(32'hffffff74);
        chk("t5_bad1", bus.dataout, 32'h0);
        chk_irq("t5_bad1_irq", 1'b1);
        rd(32'h00000060);
        chk("t5_bad2", bus.dataout, 32'h0);
        rd(32'hffffff6c);
        chk("t5_status", bus.dataout, 32'h1);

        // 6: reset mid-debounce
        sw_in = 8'hA4;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("t6_rst_dout", bus.dataout, 32'h0);
        chk_irq("t6_rst_irq", 1'b0);
        rst = 1'b0;
        repeat (5) step();
        chk_irq("t6_early", 1'b0);
        step();
        chk_irq("t6_on_time", 1'b1);
        rd(32'hffffff68);
        chk("t6_sw", bus.dataout, 32'hA4);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(399) == 0);
            if ($urandom_range(9) == 0)
                sw_in = sw_in ^ 8'($urandom);
            if ($urandom_range(11) == 0)
                key_in = 4'($urandom);
            bus.re   = ($urandom_range(2) == 0);
            bus.addr = addrs[$urandom_range(6)];
            step();
        end
        rst    = 1'b0;
        bus.re = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
